// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, sync-polarity encodings and total-period helpers.
package vga_timing_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  localparam bit SyncActiveLow  = 1'b0;
  localparam bit SyncActiveHigh = 1'b1;

  function automatic int unsigned calc_h_total(int unsigned active, int unsigned fp,
                                               int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned calc_v_total(int unsigned active, int unsigned fp,
                                               int unsigned sync, int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register; every stage loads a reset value so no stale data survives reset.
module sync_delay_line #(
  parameter int unsigned       Depth    = 2,
  parameter int unsigned       Width    = 3,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stage_q[i] <= ResetVal;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[Depth-1];

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: beam coordinates in the lookahead domain, sync/de delayed to line up
// with the consumer's pipelined pixel output.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DefHActive,
  parameter int unsigned H_FP      = DefHFp,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BP      = DefHBp,
  parameter int unsigned V_ACTIVE  = DefVActive,
  parameter int unsigned V_FP      = DefVFp,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BP      = DefVBp,
  parameter bit          SYNC_POL  = SyncActiveLow,
  parameter int unsigned LOOKAHEAD = 2,
  parameter int unsigned CW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count,
  output logic          hsync,
  output logic          vsync,
  output logic          de
);

  localparam int unsigned HTotal = calc_h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = calc_v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (LOOKAHEAD < 1 || LOOKAHEAD > 4) begin : gen_bad_lookahead
    $error("vga_timing: LOOKAHEAD must be within 1..4");
  end
  if (64'(HTotal - 1) >= (64'd1 << CW) || 64'(VTotal - 1) >= (64'd1 << CW)) begin : gen_bad_cw
    $error("vga_timing: CW too narrow for the line or frame total");
  end

  localparam logic [CW-1:0] HLast       = CW'(HTotal - 1);
  localparam logic [CW-1:0] VLast       = CW'(VTotal - 1);
  localparam logic [CW-1:0] HActiveC    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActiveC    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSyncFirst  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSyncLast   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VSyncFirst  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSyncLast   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  // Pin encoding of an idle sync line, with de cleared.
  localparam logic [2:0]    DelayRstVal = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic [7:0]    frame_q, frame_d;
  logic          hsync_raw, vsync_raw;
  logic [2:0]    delay_in, delay_out;

  always_comb begin
    hcnt_d  = hcnt_q + CW'(1);
    vcnt_d  = vcnt_q;
    frame_d = frame_q;
    if (hcnt_q == HLast) begin
      hcnt_d = '0;
      if (vcnt_q == VLast) begin
        vcnt_d  = '0;
        frame_d = frame_q + 8'd1;
      end else begin
        vcnt_d = vcnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      frame_q <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      frame_q <= frame_d;
    end
  end

  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign frame_count = frame_q;
  assign active      = (hcnt_q < HActiveC) && (vcnt_q < VActiveC);
  assign line_start  = !reset && (hcnt_q == '0);
  assign frame_start = line_start && (vcnt_q == '0);

  assign hsync_raw = (hcnt_q >= HSyncFirst) && (hcnt_q <= HSyncLast);
  assign vsync_raw = (vcnt_q >= VSyncFirst) && (vcnt_q <= VSyncLast);
  assign delay_in  = {~(hsync_raw ^ SYNC_POL), ~(vsync_raw ^ SYNC_POL), active};

  sync_delay_line #(
    .Depth    (LOOKAHEAD),
    .Width    (3),
    .ResetVal (DelayRstVal)
  ) u_sync_delay (
    .clk   (clk),
    .reset (reset),
    .din   (delay_in),
    .dout  (delay_out)
  );

  assign hsync = delay_out[2];
  assign vsync = delay_out[1];
  assign de    = delay_out[0];

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench: default 640x480 instance plus a tiny-timing instance, both compared
// every cycle against an arithmetic model of the raster position.
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [9:0] x_a, y_a;
  logic [3:0] x_b, y_b;
  logic       act_a, ls_a, fs_a, hs_a, vs_a, de_a;
  logic       act_b, ls_b, fs_b, hs_b, vs_b, de_b;
  logic [7:0] fc_a, fc_b;

  vga_timing u_dut_a (
    .clk (clk), .reset (rst_a), .x (x_a), .y (y_a), .active (act_a),
    .line_start (ls_a), .frame_start (fs_a), .frame_count (fc_a),
    .hsync (hs_a), .vsync (vs_a), .de (de_a)
  );

  vga_timing #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1'b1), .LOOKAHEAD (3), .CW (4)
  ) u_dut_b (
    .clk (clk), .reset (rst_b), .x (x_b), .y (y_b), .active (act_b),
    .line_start (ls_b), .frame_start (fs_b), .frame_count (fc_b),
    .hsync (hs_b), .vsync (vs_b), .de (de_b)
  );

  typedef struct {
    int   c;
    int   x;
    int   y;
    int   fc;
    logic act, ls, fs, hs, vs, de;
  } exp_t;

  typedef struct {
    int   c;
    logic hs;
    logic de;
  } spot_t;

  // Hand-derived pin levels for instance A (active-low sync, 2-cycle lookahead).
  spot_t spots [11] = '{
    '{0, 1'b1, 1'b0},   '{1, 1'b1, 1'b0},   '{2, 1'b1, 1'b1},   '{641, 1'b1, 1'b1},
    '{642, 1'b1, 1'b0}, '{657, 1'b1, 1'b0}, '{658, 1'b0, 1'b0}, '{753, 1'b0, 1'b0},
    '{754, 1'b1, 1'b0}, '{801, 1'b1, 1'b0}, '{802, 1'b1, 1'b1}
  };

  exp_t  q_a [$];
  exp_t  q_b [$];
  spot_t q_spot [$];
  int    errors = 0;
  int    checks = 0;
  bit    b_wrapped = 1'b0;

  function automatic exp_t model(int c, logic rst, int ha, int hf, int hsw, int hb, int va,
                                 int vf, int vsw, int vb, int la, logic pol);
    exp_t e;
    int ht, vt, p, ph, pv;
    ht    = ha + hf + hsw + hb;
    vt    = va + vf + vsw + vb;
    e.c   = c;
    e.x   = c % ht;
    e.y   = (c / ht) % vt;
    e.fc  = (c / (ht * vt)) % 256;
    e.act = (e.x < ha) && (e.y < va);
    e.ls  = !rst && (e.x == 0);
    e.fs  = e.ls && (e.y == 0);
    if (c < la) begin
      e.hs = ~pol;
      e.vs = ~pol;
      e.de = 1'b0;
    end else begin
      p    = c - la;
      ph   = p % ht;
      pv   = (p / ht) % vt;
      e.hs = (ph >= ha + hf && ph < ha + hf + hsw) ? pol : ~pol;
      e.vs = (pv >= va + vf && pv < va + vf + vsw) ? pol : ~pol;
      e.de = (ph < ha) && (pv < va);
    end
    return e;
  endfunction

  task automatic check_rec(string name, exp_t e, int x, int y, logic act, logic ls, logic fs,
                           logic hs, logic vs, logic de, int fc);
    checks++;
    if (e.x != x || e.y != y || e.fc != fc || act !== e.act || ls !== e.ls || fs !== e.fs ||
        hs !== e.hs || vs !== e.vs || de !== e.de) begin
      errors++;
      $display("FAIL %s c=%0d got x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b de=%b fc=%0d",
               name, e.c, x, y, act, ls, fs, hs, vs, de, fc);
      $display("     %s c=%0d want x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b de=%b fc=%0d",
               name, e.c, e.x, e.y, e.act, e.ls, e.fs, e.hs, e.vs, e.de, e.fc);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Stimulus: drives resets and pushes the expected view of each cycle.
  initial begin
    int  c_a = 0, c_b = 0;
    bit  done_a = 1'b0, done_b = 1'b0, finished = 1'b0;
    for (int k = 0; k < 40000; k++) begin
      @(posedge clk);
      #1;
      c_a = rst_a ? 0 : c_a + 1;
      c_b = rst_b ? 0 : c_b + 1;
      if (k < 4) begin
        rst_a = 1'b1;
        rst_b = 1'b1;
      end else begin
        // A: mid-hsync reset at hcnt 700 of line 3; B: mid-vsync reset on line 6 of frame 256.
        rst_a = !done_a && (c_a == 3 * 800 + 700);
        rst_b = !done_b && (c_b == 256 * 112 + 6 * 14 + 5);
        if (rst_a) done_a = 1'b1;
        if (rst_b) done_b = 1'b1;
      end
      q_a.push_back(model(c_a, rst_a, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0));
      q_b.push_back(model(c_b, rst_b, 8, 2, 3, 1, 4, 1, 2, 1, 3, 1'b1));
      foreach (spots[i]) if (spots[i].c == c_a) q_spot.push_back(spots[i]);
      if (done_b && !rst_b && c_b >= 400) begin
        finished = 1'b1;
        break;
      end
    end
    @(negedge clk);
    #1;
    check_int("run_complete", int'(finished), 1);
    check_int("b_frame_count_wrapped", int'(b_wrapped), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Monitor for instance A.
  initial begin
    exp_t  e;
    spot_t s;
    int    cyc = 0, last_ls = -1, hrun = 0, derun = 0;
    bit    hlow = 1'b0, htaint = 1'b0, dehigh = 1'b0, detaint = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (q_spot.size() > 0) begin
        s = q_spot.pop_front();
        check_int($sformatf("a_spot_hsync_c%0d", s.c), int'(hs_a), int'(s.hs));
        check_int($sformatf("a_spot_de_c%0d", s.c), int'(de_a), int'(s.de));
      end
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check_rec("dut_a", e, int'(x_a), int'(y_a), act_a, ls_a, fs_a, hs_a, vs_a, de_a,
                  int'(fc_a));
        if (rst_a) last_ls = -1;
        else if (ls_a) begin
          if (last_ls >= 0) check_int("a_line_period", cyc - last_ls, 800);
          last_ls = cyc;
        end
        if (hs_a == 1'b0) begin
          if (!hlow) begin hlow = 1'b1; hrun = 0; htaint = 1'b0; end
          hrun++;
          if (rst_a) htaint = 1'b1;
        end else begin
          if (hlow && !htaint) check_int("a_hsync_width", hrun, 96);
          hlow = 1'b0;
        end
        if (de_a == 1'b1) begin
          if (!dehigh) begin dehigh = 1'b1; derun = 0; detaint = 1'b0; end
          derun++;
          if (rst_a) detaint = 1'b1;
        end else begin
          if (dehigh && !detaint) check_int("a_de_width", derun, 640);
          dehigh = 1'b0;
        end
      end
    end
  end

  // Monitor for instance B.
  initial begin
    exp_t e;
    int   cyc = 0, last_fs = -1, prev_fc = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check_rec("dut_b", e, int'(x_b), int'(y_b), act_b, ls_b, fs_b, hs_b, vs_b, de_b,
                  int'(fc_b));
        if (rst_b) last_fs = -1;
        else if (fs_b) begin
          if (last_fs >= 0) check_int("b_frame_period", cyc - last_fs, 112);
          last_fs = cyc;
        end
        if (prev_fc == 255 && fc_b == 8'd0) b_wrapped = 1'b1;
        prev_fc = int'(fc_b);
      end
    end
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Upstream stage of `rasterizer` that generates VGA raster timing at one pixel per `clk` (25.175 MHz nominal, 640x480@60).
- Provides the rasterizer with raw beam coordinates LOOKAHEAD cycles early, so a pipelined pixel computation can finish in time.
- Provides `hsync`, `vsync` and display-enable, delayed by the same LOOKAHEAD cycles, so they line up with the `rgb` the rasterizer produces.
- Also provides line and frame strobes, plus a free-running frame counter for animation.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, 0 = sync pulses active-low, 1 = active-high (applies to both)
- LOOKAHEAD, 2, pipeline depth of the consumer; legal range 1..4
- CW, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- x  out  CW  raw horizontal counter hcnt, 0..H_TOTAL-1 (lookahead domain)
- y  out  CW  raw vertical counter vcnt, 0..V_TOTAL-1 (lookahead domain)
- active  out  1  hcnt<H_ACTIVE && vcnt<V_ACTIVE (lookahead domain)
- line_start  out  1  one-cycle pulse when hcnt==0 (lookahead domain)
- frame_start  out  1  one-cycle pulse when hcnt==0 && vcnt==0 (lookahead domain)
- frame_count  out  8  completed-frame counter
- hsync  out  1  horizontal sync, delayed LOOKAHEAD cycles
- vsync  out  1  vertical sync, delayed LOOKAHEAD cycles
- de  out  1  display enable, equal to `active` delayed LOOKAHEAD cycles

Behaviour:
- Interface: one clock, `clk`. `reset` is synchronous and active-high; all state changes only on the rising edge of `clk`.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- hcnt advances by 1 every cycle. At H_TOTAL-1 it wraps to 0 and vcnt advances by 1.
- vcnt wraps from V_TOTAL-1 to 0 on the same edge that hcnt wraps. frame_count increments on that edge and wraps 255 -> 0.
- x, y, active, line_start and frame_start are combinational decodes of the counter registers (zero latency relative to the counters).
- Raw hsync is asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751 with defaults.
- Raw vsync is asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491, for every cycle of those lines.
- Output pins: pin level = raw XNOR SYNC_POL. Asserted level is 0 when SYNC_POL=0; inactive level is its complement.
- Delay alignment: hsync, vsync and de pass through a LOOKAHEAD-deep register chain. The pin value at cycle t reflects the counter state at cycle t-LOOKAHEAD.
- While reset is high:
  - hcnt=0, vcnt=0, frame_count=0.
  - line_start=0 and frame_start=0 (strobes are gated by reset).
  - Every delay stage is loaded with inactive sync levels and de=0, so hsync/vsync sit at the inactive level.
- First cycle after reset deasserts: hcnt=0, vcnt=0, so line_start=1 and frame_start=1. de goes high LOOKAHEAD cycles later.
- Reset asserted mid-frame takes effect on the next edge. There is no partial pulse: sync pins return to inactive from the first reset cycle onward, because every stage is cleared.
- No input handshake. The consumer must accept one pixel per cycle, unconditionally.
- Elaboration check: fail elaboration (generate-time error) if LOOKAHEAD is outside 1..4, or if CW is too narrow for H_TOTAL-1 or V_TOTAL-1.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480 timing constants;
  - H_TOTAL/V_TOTAL computation functions;
  - the sync-polarity constants.
- One sub-module, sync_delay_line: a parametric-depth, parametric-width shift register with synchronous reset to a parameterised reset value. Instantiated once, 3 bits wide (hsync, vsync, de).

Test Plan:
- Reset values: hold reset 5 cycles -> hsync=1, vsync=1, de=0, x=0, y=0, frame_count=0, strobes 0. Release -> frame_start=1 and line_start=1 in the first cycle, de=1 exactly LOOKAHEAD(2) cycles later.
- Line timing (defaults): count cycles between line_start pulses -> 800. hsync low for exactly 96 cycles, first low at 656+2 cycles after line_start. de high for exactly 640 cycles per visible line.
- Frame timing: cycles between frame_start pulses -> 420000. vsync low only during lines 490-491 (shifted 2 cycles). de=0 for all of lines 480..524.
- Small-param sim (H 8/2/3/1, V 4/1/2/1, LOOKAHEAD=3, SYNC_POL=1): hsync high for hcnt 10..12 shifted 3 cycles. frame_count wraps 255->0 after 256 frames with no glitch on strobes.
- Reset mid-hsync pulse (hcnt=700, line 100): assert reset 1 cycle -> hsync inactive from the next cycle, counters 0, and the line restarts with a full 800-cycle period.
- Reset mid-vsync (line 491): vsync inactive on the next cycle. The next vsync pulse appears 490 lines after the reset release.
